uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
- UART receiver that consumes the 16x-oversampling Tick pulse produced by the team's baud-rate generator.
- Synchronises the serial RxD line, detects and qualifies the start bit, and samples each bit at mid-bit.
- Assembles the data word LSB-first, with optional parity and stop-bit checking.
- Presents each received word through a hold-until-acknowledged valid/ack interface with sticky error flags.
- Sits between the pad-side RxD input and the user/CPU logic; shares Clk and Tick with the transmit path.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal range 5..9.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

Ports:
- Clk  input  1  system clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Tick  input  1  one-Clk-wide pulse at 16x the baud rate.
- RxD  input  1  asynchronous serial line; idle high.
- RxData  output  DATA_BITS  last received word.
- RxValid  output  1  RxData holds an unread word.
- RxAck  input  1  consumer read strobe; clears RxValid.
- ParityErr  output  1  parity mismatch on the word in RxData.
- FrameErr  output  1  stop bit sampled low on the word in RxData.
- Overrun  output  1  a word was overwritten before it was acknowledged (sticky).
- Busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, Rst_n low):
  - FSM = IDLE; tick counter = 0; bit counter = 0.
  - Synchroniser flops = 1.
  - RxData = 0; RxValid, ParityErr, FrameErr, Overrun, Busy = 0.
- Reset asserted mid-frame aborts the frame immediately. No partial word is ever delivered.
- RxD passes through a 2-flop synchroniser. All decisions use the synchronised value (rxs).
- The FSM advances only on Clk edges where Tick = 1. With Tick = 0, all state holds.
- The tick counter is 4 bits and wraps 15 -> 0.
- IDLE:
  - On Tick with rxs = 0 -> START, counter = 0.
- START (qualifies the start bit):
  - On each Tick, counter increments.
  - When counter = 7 (8th tick, mid start bit) and rxs = 0 -> DATA, counter = 0, bit count = 0.
  - When counter = 7 and rxs = 1 -> IDLE. This is a glitch reject: no output, no error.
- DATA:
  - When counter = 15, sample rxs into the shift register MSB, shifting right so the word is LSB-first.
  - Bit count increments on each sample.
  - After DATA_BITS samples -> PARITY if PARITY_EN = 1, else -> STOP.
  - Counter resets on each sample.
- PARITY:
  - When counter = 15, sample rxs.
  - perr = (XOR of data bits ^ sample ^ PARITY_ODD) != 0.
  - Then -> STOP.
- STOP:
  - When counter = 15, sample rxs; ferr = ~rxs.
  - On that same edge: load RxData = shift register; ParityErr = perr (0 when PARITY_EN = 0); FrameErr = ferr; RxValid = 1.
  - FSM -> IDLE on that same edge.
  - The return to IDLE happens at mid stop bit, so a start edge arriving 8 ticks later is still caught.
- Latency: RxValid rises on the Clk edge of the stop-bit sample tick, i.e. 8 + 16*(DATA_BITS + PARITY_EN + 1) ticks after start-edge detection.
- Handshake:
  - RxAck with RxValid = 1 clears RxValid and Overrun on the next edge.
  - RxAck with RxValid = 0 has no effect.
  - RxData, ParityErr and FrameErr hold their values until the next word loads.
- Word completes while RxValid = 1 and RxAck = 0: RxData and the error flags are overwritten, RxValid stays 1, Overrun = 1.
- Word completes in the same cycle as RxAck: the new word loads, RxValid stays 1, and Overrun is not set; a previously set Overrun is cleared.
- A line held low (break condition) yields a word 0x00 with FrameErr = 1. The FSM then re-enters START on the next Tick while rxs = 0; the line must return high before any further valid frame is received.
- Busy = (state != IDLE), registered.

Test Plan:
- Setup for all scenarios: Tick every 4 Clk, so one bit = 64 Clk; DATA_BITS = 8 unless noted.
- Clean frame: send 0xA5, 8N1 -> RxData = 0xA5, RxValid = 1, ParityErr = FrameErr = Overrun = 0; RxValid rises 8 + 16*9 = 152 ticks after start detection; RxAck clears RxValid next cycle.
- Glitch reject: drive RxD low for 5 ticks, then high -> FSM returns to IDLE, RxValid stays 0; a following 0x3C frame is received correctly.
- Errors (PARITY_EN = 1, even parity):
  - send 0x0F with parity bit 1 -> ParityErr = 1;
  - send 0x55 with stop bit 0 -> FrameErr = 1, RxData = 0x55.
- Overrun: send 0x11 then 0x22 back-to-back with no RxAck -> RxData = 0x22, Overrun = 1; RxAck then clears RxValid and Overrun.
- Ack collision: assert RxAck on the exact cycle the second word completes -> RxValid stays 1, Overrun = 0, RxData = new word.
- Reset mid-frame: assert Rst_n low during data bit 3 -> all outputs 0 and Busy = 0; after release, a 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by a 16x oversampling tick: start-bit qualification, mid-bit sampling,
// optional parity, stop-bit check and a hold-until-acknowledged output register.
module uart_rx_oversampled #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Tick,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxAck,
  output logic                 ParityErr,
  output logic                 FrameErr,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam logic [3:0] LastBit = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 rxs;
  logic                 word_done;
  logic                 ferr;

  assign sync_d = {sync_q[0], RxD};
  assign rxs    = sync_q[1];

  // Frame FSM: every decision is gated by Tick so the state holds between ticks.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    word_done  = 1'b0;
    ferr       = 1'b0;

    if (Tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_d    = StStart;
            tick_cnt_d = 4'd0;
          end
        end
        StStart: begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            if (!rxs) begin
              state_d   = StData;
              bit_cnt_d = 4'd0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        StData: begin
          // Counter wraps 15 -> 0, which doubles as the per-sample reset.
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LastBit) begin
              state_d = PARITY_EN ? StParity : StStop;
            end
          end
        end
        StParity: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            perr_d  = ^{shift_q, rxs, PARITY_ODD};
            state_d = StStop;
          end
        end
        StStop: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            // Leaving at mid stop bit keeps half a bit of slack for the next start edge.
            word_done = 1'b1;
            ferr      = ~rxs;
            state_d   = StIdle;
          end
        end
        default: begin
          state_d    = StIdle;
          tick_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Output register and valid/ack handshake.
  always_comb begin
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = overrun_q;
    busy_d       = (state_d != StIdle);

    if (word_done) begin
      rx_data_d    = shift_q;
      parity_err_d = PARITY_EN & perr_q;
      frame_err_d  = ferr;
    end

    if (word_done) begin
      rx_valid_d = 1'b1;
    end else if (RxAck) begin
      rx_valid_d = 1'b0;
    end

    // An ack landing with a new word counts as reading the old one, so no overrun.
    if (RxAck && rx_valid_q) begin
      overrun_d = 1'b0;
    end else if (word_done && rx_valid_q) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= StIdle;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign RxData    = rx_data_q;
  assign RxValid   = rx_valid_q;
  assign ParityErr = parity_err_q;
  assign FrameErr  = frame_err_q;
  assign Overrun   = overrun_q;
  assign Busy      = busy_q;

endmodule
